spi_sram_slave: RTL and testbench

SPI_SRAM_SLAVE -- requirements
Module: spi_sram_slave

---
 rtl/spi_sram_pkg.sv | 17 +
 rtl/spi_sram_miso_out.sv | 25 ++
 rtl/spi_sram_slave.sv | 109 ++++++++++
 tb/tb_spi_sram_slave.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/spi_sram_pkg.sv
// Shared constants and types for the SPI SRAM slave.
package spi_sram_pkg;
  localparam int ADDR_W = 24;
  localparam int DATA_W = 8;

  localparam logic [6:0] OP_READ      = 7'h03;
  localparam logic [6:0] OP_WRITE     = 7'h02;
  localparam logic [6:0] OP_FAST_READ = 7'h0B;

  typedef enum logic [2:0] {
    ST_CMD,
    ST_ADDR,
    ST_READ,
    ST_WRITE,
    ST_IGNORE
  } state_t;
endpackage

// File: rtl/spi_sram_miso_out.sv
// clkb-domain byte load/shift register that launches miso MSB first.
import spi_sram_pkg::*;

module spi_sram_miso_out (
  input  logic              clkb,
  input  logic              rst,
  input  logic              enb,
  input  logic              clr,
  input  logic              load,
  input  logic [DATA_W-1:0] din,
  output logic              miso
);
  logic [DATA_W-2:0] sh;

  // {miso, sh} is the whole byte; shifting in zeros keeps miso low after the last byte.
  always_ff @(posedge clkb) begin
    if (rst) begin
      {miso, sh} <= '0;
    end else if (enb) begin
      if (clr)       {miso, sh} <= '0;
      else if (load) {miso, sh} <= din;
      else           {miso, sh} <= {sh, 1'b0};
    end
  end
endmodule

// File: rtl/spi_sram_slave.sv
// SPI slave bridging command/address/data frames onto a synchronous byte RAM.
// Define SPI_SRAM_SLAVE_FAST_READ_EN to accept opcode 0x0B (read with 8 dummy clocks).
import spi_sram_pkg::*;

module spi_sram_slave (
  input  logic              clk,
  input  logic              clkb,
  input  logic              rst,
  input  logic              en,
  input  logic              enb,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  state_t            state;
  logic [4:0]        cnt;
  logic [ADDR_W-2:0] sh;
  logic [ADDR_W-1:0] addr;
  logic              wr_mode, fast_mode, load_q;

  logic [ADDR_W-1:0] addr_in;
  logic [DATA_W-1:0] byte_in;
  logic [6:0]        op;
  logic              active, last_addr, rd_fetch, wr_strobe;
  logic              is_rd, is_wr, is_fast;

  assign addr_in   = {sh, mosi};
  assign byte_in   = {sh[DATA_W-2:0], mosi};
  assign op        = {sh[5:0], mosi};
  assign active    = en && !cs_n && !rst;
  assign last_addr = (state == ST_ADDR) && (cnt == 5'd23);

  always_comb begin
    is_rd   = (op == OP_READ);
    is_wr   = (op == OP_WRITE);
    is_fast = 1'b0;
`ifdef SPI_SRAM_SLAVE_FAST_READ_EN
    is_fast = (op == OP_FAST_READ);
`endif
  end

  // Plain reads fetch on the last address bit; fast reads fetch at the end of the dummy byte.
  assign rd_fetch  = active && ((last_addr && !wr_mode && !fast_mode) ||
                                (state == ST_READ && cnt == 5'd7));
  assign wr_strobe = active && (state == ST_WRITE) && (cnt == 5'd7);

  assign mem_en    = rd_fetch || wr_strobe;
  assign mem_wr    = wr_strobe;
  assign mem_wdata = wr_strobe ? byte_in : '0;
  assign mem_addr  = rst ? '0 : ((state == ST_ADDR) ? addr_in : addr);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_CMD;
      cnt       <= '0;
      sh        <= '0;
      addr      <= '0;
      wr_mode   <= 1'b0;
      fast_mode <= 1'b0;
      load_q    <= 1'b0;
    end else if (en) begin
      if (cs_n) begin
        state  <= ST_CMD;
        cnt    <= '0;
        sh     <= '0;
        load_q <= 1'b0;
      end else begin
        sh     <= addr_in[ADDR_W-2:0];
        cnt    <= cnt + 5'd1;
        load_q <= rd_fetch;
        case (state)
          ST_CMD: if (cnt == 5'd7) begin
            cnt       <= '0;
            wr_mode   <= is_wr;
            fast_mode <= is_fast;
            state     <= (is_rd || is_wr || is_fast) ? ST_ADDR : ST_IGNORE;
          end
          ST_ADDR: if (cnt == 5'd23) begin
            cnt   <= '0;
            state <= wr_mode ? ST_WRITE : ST_READ;
            // a plain read has already fetched addr_in, so the next fetch is one past it
            addr  <= (wr_mode || fast_mode) ? addr_in : addr_in + 24'd1;
          end
          ST_READ, ST_WRITE: if (cnt == 5'd7) begin
            cnt  <= '0;
            addr <= addr + 24'd1;
          end
          ST_IGNORE: cnt <= '0;
          default:   state <= ST_CMD;
        endcase
      end
    end
  end

  spi_sram_miso_out u_miso (
    .clkb (clkb),
    .rst  (rst),
    .enb  (enb),
    .clr  (cs_n),
    .load (load_q),
    .din  (mem_rdata),
    .miso (miso)
  );
endmodule

// File: tb/tb_spi_sram_slave.sv
// Directed and randomized frames for spi_sram_slave checked against a byte-level model.
module tb_spi_sram_slave;
  logic        clk = 1'b0;
  logic        clkb;
  logic        rst, en, enb, cs_n, mosi, miso;
  logic [23:0] mem_addr;
  logic        mem_en, mem_wr;
  logic [7:0]  mem_wdata, mem_rdata;

  logic        pl_we;
  logic [15:0] pl_a;
  logic [7:0]  pl_d;

  logic [7:0]  ram     [0:65535];
  logic [7:0]  ref_mem [0:65535];

  int tests = 0;
  int fails = 0;

  assign clkb = ~clk;
  always #5 clk = ~clk;

  spi_sram_slave dut (
    .clk(clk), .clkb(clkb), .rst(rst), .en(en), .enb(enb), .cs_n(cs_n),
    .mosi(mosi), .miso(miso), .mem_addr(mem_addr), .mem_en(mem_en),
    .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Synchronous RAM; the low 16 address bits select the byte.
  always @(posedge clk) begin
    if (pl_we) ram[pl_a] <= pl_d;
    else if (mem_en) begin
      if (mem_wr) ram[mem_addr[15:0]] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr[15:0]];
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk); #1;
    pl_we = 1'b1; pl_a = a; pl_d = d;
    ref_mem[a] = d;
    @(posedge clk); #1;
    pl_we = 1'b0;
  endtask

  function automatic logic exp_bit(input bit rd, input int first, input logic [23:0] a, input int j);
    logic [23:0] ba;
    int o;
    if (!rd || j < first) return 1'b0;
    o  = j - first;
    ba = a + 24'(o / 8);
    return ref_mem[ba[15:0]][7 - (o % 8)];
  endfunction

  task automatic run_frame(input string tag, input logic [7:0] cmd, input logic [23:0] a,
                           input int ndata, input logic [63:0] wd,
                           input int stall_at, input int stall_len);
    logic [31:0] hdr;
    logic [23:0] ak;
    bit rd, wr, fast, ee;
    int first, total, k;
    logic b;
    hdr  = {cmd, a};
    fast = 1'b0;
`ifdef SPI_SRAM_SLAVE_FAST_READ_EN
    fast = (cmd[6:0] == 7'h0B);
`endif
    rd    = (cmd[6:0] == 7'h03) || fast;
    wr    = (cmd[6:0] == 7'h02);
    first = fast ? 40 : 32;
    total = 32 + ndata;
    for (int j = 0; j < total; j++) begin
      b = (j < 32) ? hdr[31 - j] : wd[63 - (j - 32)];
      if (j == stall_at) begin
        repeat (stall_len) begin
          @(negedge clk); #1;
          en = 1'b0; enb = 1'b0; mosi = 1'($urandom);
          #1 check({tag, "_stall_en"}, 64'(mem_en), 64'(0));
          @(posedge clk); #1;
          check({tag, "_stall_miso"}, 64'(miso), 64'(exp_bit(rd, first, a, j)));
        end
      end
      @(negedge clk); #1;
      rst = 1'b0; cs_n = 1'b0; en = 1'b1; enb = 1'b1; mosi = b;
      #1;
      ee = 1'b0; k = 0;
      if (rd && j >= first - 1 && (j - first + 1) % 8 == 0) begin ee = 1'b1; k = (j - first + 1) / 8; end
      if (wr && j >= 39 && (j - 39) % 8 == 0) begin ee = 1'b1; k = (j - 39) / 8; end
      ak = a + 24'(k);
      check({tag, "_strobe"}, 64'({mem_en, mem_wr}), 64'({ee, ee && wr}));
      if (ee) check({tag, "_addr"}, 64'(mem_addr), 64'(ak));
      if (ee && wr) check({tag, "_wdata"}, 64'(mem_wdata), 64'(wd[63 - 8*k -: 8]));
      @(posedge clk); #1;
      check({tag, "_miso"}, 64'(miso), 64'(exp_bit(rd, first, a, j)));
    end
    if (wr) begin
      for (int kk = 0; kk < ndata / 8; kk++) begin
        ak = a + 24'(kk);
        ref_mem[ak[15:0]] = wd[63 - 8*kk -: 8];
      end
    end
    @(negedge clk); #1;
    cs_n = 1'b1; mosi = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check({tag, "_idle_miso"}, 64'(miso), 64'(0));
  endtask

  initial begin
    logic [31:0] hdr;
    logic [7:0]  c;
    logic [7:0]  ops [5];
    rst = 1'b1; en = 1'b1; enb = 1'b1; cs_n = 1'b1; mosi = 1'b0;
    pl_we = 1'b0; pl_a = '0; pl_d = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_en", 64'(mem_en), 64'(0));
    check("rst_mem_wr", 64'(mem_wr), 64'(0));
    check("rst_mem_addr", 64'(mem_addr), 64'(0));
    check("rst_mem_wdata", 64'(mem_wdata), 64'(0));
    check("rst_miso", 64'(miso), 64'(0));
    @(negedge clk); #1 rst = 1'b0;

    for (int i = 0; i < 32; i++) preload(16'h0400 + 16'(i), 8'($urandom));
    for (int i = 0; i < 6; i++)  preload(16'h0407 + 16'(i), 8'h77 + 8'(i * 17));
    preload(16'hFFFF, 8'h5A);
    preload(16'h0000, 8'hC3);

    run_frame("rd409", 8'h83, 24'h800409, 16, 64'($urandom), -1, 0);
    run_frame("wr405", 8'h82, 24'h800405, 32, {32'h11223344, 32'h0}, -1, 0);
    run_frame("rd405", 8'h83, 24'h800405, 32, 64'($urandom), -1, 0);
    run_frame("wr_part", 8'h02, 24'h800405, 4, {4'hF, 60'h0}, -1, 0);
    run_frame("rd_old", 8'h03, 24'h800405, 8, 64'($urandom), -1, 0);
    run_frame("rd_wrap", 8'h03, 24'hFFFFFF, 16, 64'($urandom), -1, 0);
    run_frame("stall_mid", 8'h83, 24'h800407, 24, 64'($urandom), 34, 4);
    run_frame("stall_fetch", 8'h03, 24'h80040A, 16, 64'($urandom), 39, 2);
    run_frame("op05", 8'h05, 24'h800409, 16, 64'($urandom), -1, 0);
    run_frame("op0b", 8'h0B, 24'h800409, 24, 64'($urandom), -1, 0);

    ops[0] = 8'h03; ops[1] = 8'h83; ops[2] = 8'h02; ops[3] = 8'h82; ops[4] = 8'($urandom);
    for (int i = 0; i < 10; i++) begin
      c = ops[$urandom_range(0, 4)];
      c[7] = 1'($urandom);
      run_frame("rand", c, 24'h800400 + 24'($urandom_range(0, 15)),
                int'($urandom_range(0, 31)), {$urandom, $urandom}, -1, 0);
    end

    // abort a read in its data phase with reset while cs_n stays low
    hdr = {8'h03, 24'h800410};
    for (int j = 0; j < 37; j++) begin
      @(negedge clk); #1;
      cs_n = 1'b0; mosi = (j < 32) ? hdr[31 - j] : 1'($urandom);
    end
    repeat (2) begin
      @(negedge clk); #1;
      rst = 1'b1; mosi = 1'($urandom);
      #1;
      check("midrst_en", 64'(mem_en), 64'(0));
      check("midrst_addr", 64'(mem_addr), 64'(0));
      @(posedge clk); #1;
    end
    check("midrst_miso", 64'(miso), 64'(0));
    run_frame("after_rst", 8'h83, 24'h800408, 16, 64'($urandom), -1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
